// File: rtl/ahb_burst_arbiter_pkg.sv
// Shared AHB types and the burst beat-limit lookup used by the burst arbiter.
package AHB_package;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_type;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam logic [4:0] CNT_MAX = 5'd31;

  // A limit of zero stands for an unbounded (INCR) burst.
  function automatic logic [4:0] beat_limit(input burst_type b);
    logic [4:0] lim;
    case (b)
      SINGLE:         lim = 5'd1;
      WRAP4, INCR4:   lim = 5'd4;
      WRAP8, INCR8:   lim = 5'd8;
      WRAP16, INCR16: lim = 5'd16;
      default:        lim = 5'd0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational winner search: first requester found walking upward from start_i,
// wrapping at MASTER_NUM.
module ahb_rr_pick
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req_i,
  input  logic [MIDX_W-1:0]     start_i,
  output logic [MASTER_NUM-1:0] gnt_o,
  output logic [MIDX_W-1:0]     idx_o
);

  int                pos_s;
  logic              found_s;
  logic [MIDX_W-1:0] cand_s;

  // Priority scan starting at the pointer; only the first hit is granted.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    pos_s   = 0;
    cand_s  = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      pos_s = int'(start_i) + k;
      if (pos_s >= MASTER_NUM) pos_s = pos_s - MASTER_NUM;
      else pos_s = pos_s;
      cand_s = pos_s[MIDX_W-1:0];
      if (!found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ahb_burst_arbiter.sv
// AHB burst arbiter: holds a registered one-hot grant for a whole burst and
// re-arbitrates (fixed or round-robin) on the edge the burst ends.
module ahb_burst_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int ARB_MODE   = 0,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  burst_type             hburst,
  input  trans_type             htrans,
  input  logic                  hwait,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [MIDX_W-1:0]     hmaster,
  output logic                  hlast
);

  arb_state_t            state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MIDX_W-1:0]     master_q, master_d;
  logic [MIDX_W-1:0]     ptr_q, ptr_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            limit_q, limit_d;
  logic                  lat_q, lat_d;

  logic                  hsel_s, accept_s, hlast_s, incr_s, end_s;
  logic [4:0]            limit_s;
  logic [MIDX_W-1:0]     next_ptr_s, start_s, pick_idx_s;
  logic [MASTER_NUM-1:0] pick_gnt_s;

  assign hsel_s   = |grant_q;
  assign accept_s = hsel_s && !hwait && (htrans == NONSEQ || htrans == SEQ);
  // Before the first NONSEQ is latched the live hburst decides, so SINGLE flags its only beat.
  assign limit_s  = lat_q ? limit_q : beat_limit(hburst);
  assign hlast_s  = hsel_s && (limit_s != 5'd0) && (cnt_q == limit_s - 5'd1);
  assign incr_s   = lat_q && (limit_q == 5'd0);
  assign end_s    = (state_q == ARB_BURST) &&
                    ((accept_s && hlast_s) ||
                     (incr_s && !hwait && (htrans == IDLE || htrans == NONSEQ) && (cnt_q != 5'd0)) ||
                     (!hreq[master_q] && htrans == IDLE && !hwait));
  assign next_ptr_s = (master_q == MIDX_W'(MASTER_NUM - 1)) ? '0 : master_q + MIDX_W'(1);

  // Search start: the pointer in round-robin, index 0 in fixed priority.
  always_comb begin
    if (ARB_MODE == 1) begin
      if (state_q == ARB_BURST) start_s = next_ptr_s;
      else start_s = ptr_q;
    end else begin
      start_s = '0;
    end
  end

  ahb_rr_pick #(
    .MASTER_NUM (MASTER_NUM),
    .MIDX_W     (MIDX_W)
  ) u_pick (
    .req_i   (hreq),
    .start_i (start_s),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state logic: grant hand-over, beat counting and limit latching.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    lat_d    = lat_q;
    case (state_q)
      ARB_IDLE: begin
        // Ownership only changes while the bus is not stalled.
        if (|hreq && !hwait) begin
          state_d  = ARB_BURST;
          grant_d  = pick_gnt_s;
          master_d = pick_idx_s;
          cnt_d    = 5'd0;
          lat_d    = 1'b0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (end_s) begin
          ptr_d   = next_ptr_s;
          cnt_d   = 5'd0;
          lat_d   = 1'b0;
          limit_d = 5'd0;
          if (|hreq) begin
            grant_d  = pick_gnt_s;
            master_d = pick_idx_s;
          end else begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            master_d = '0;
          end
        end else if (accept_s) begin
          if (htrans == NONSEQ && !lat_q) begin
            lat_d   = 1'b1;
            limit_d = beat_limit(hburst);
          end else begin
            lat_d = lat_q;
          end
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        grant_d  = '0;
        master_d = '0;
        cnt_d    = 5'd0;
        lat_d    = 1'b0;
      end
    endcase
  end

  // State registers, cleared asynchronously by hreset_n.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      master_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= 5'd0;
      limit_q  <= 5'd0;
      lat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      lat_q    <= lat_d;
    end
  end

  assign hgrant  = grant_q;
  assign hsel    = hsel_s;
  assign hmaster = master_q;
  assign hlast   = hlast_s;

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Bench for ahb_burst_arbiter: fixed and round-robin instances share stimulus and are
// checked against hand-written vectors and a behavioural model.
module tb_ahb_burst_arbiter;
  import AHB_package::*;

  localparam int N = 4;

  logic      hclk;
  logic      hreset_n;
  logic      hwait;
  logic [3:0] hreq;
  burst_type hburst;
  trans_type htrans;

  logic [3:0] gnt_f, gnt_r;
  logic       sel_f, sel_r, last_f, last_r;
  logic [1:0] mst_f, mst_r;

  int n_chk  = 0;
  int n_pass = 0;

  int m_owner[2];
  int m_beats[2];
  int m_lim[2];
  int m_lat[2];
  int m_ptr[2];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    burst_type  burst;
    trans_type  trans;
    logic       wt;
    logic [3:0] gf;
    logic       lf;
    logic [3:0] gr;
    logic       lr;
  } vec_t;

  vec_t tbl[$];

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  ahb_burst_arbiter #(.MASTER_NUM(N), .ARB_MODE(0)) u_fix (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .htrans(htrans),
    .hwait(hwait), .hgrant(gnt_f), .hsel(sel_f), .hmaster(mst_f), .hlast(last_f)
  );

  ahb_burst_arbiter #(.MASTER_NUM(N), .ARB_MODE(1)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .htrans(htrans),
    .hwait(hwait), .hgrant(gnt_r), .hsel(sel_r), .hmaster(mst_r), .hlast(last_r)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] q, input burst_type b, input trans_type t,
                     input logic w, input logic [3:0] gf, input logic lf, input logic [3:0] gr,
                     input logic lr);
    tbl.push_back('{r, q, b, t, w, gf, lf, gr, lr});
  endtask

  function automatic int lim_of(input burst_type b);
    case (b)
      SINGLE:        return 1;
      INCR:          return 0;
      WRAP4, INCR4:  return 4;
      WRAP8, INCR8:  return 8;
      default:       return 16;
    endcase
  endfunction

  function automatic int pick(input int start);
    for (int k = 0; k < N; k++) begin
      int i = (start + k) % N;
      if (hreq[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_beats[m] = 0; m_lim[m] = 0; m_lat[m] = 0; m_ptr[m] = 0;
    end
  endtask

  function automatic int exp_last(input int m);
    int lim;
    if (m_owner[m] < 0) return 0;
    lim = (m_lat[m] != 0) ? m_lim[m] : lim_of(hburst);
    return (lim > 0 && m_beats[m] == lim - 1) ? 1 : 0;
  endfunction

  task automatic model_step(input int m);
    int lim;
    bit acc, last, ended;
    acc = !hwait && (htrans == NONSEQ || htrans == SEQ);
    if (m_owner[m] < 0) begin
      if (hreq != 4'd0 && !hwait) begin
        m_owner[m] = pick(m == 1 ? m_ptr[m] : 0);
        m_beats[m] = 0;
        m_lat[m]   = 0;
      end
    end else begin
      lim   = (m_lat[m] != 0) ? m_lim[m] : lim_of(hburst);
      last  = lim > 0 && m_beats[m] == lim - 1;
      ended = (acc && last) ||
              (m_lat[m] != 0 && m_lim[m] == 0 && !hwait &&
               (htrans == IDLE || htrans == NONSEQ) && m_beats[m] >= 1) ||
              (!hreq[m_owner[m]] && htrans == IDLE && !hwait);
      if (ended) begin
        m_ptr[m]   = (m_owner[m] + 1) % N;
        m_beats[m] = 0;
        m_lat[m]   = 0;
        m_owner[m] = (hreq != 4'd0) ? pick(m == 1 ? m_ptr[m] : 0) : -1;
      end else if (acc) begin
        if (htrans == NONSEQ && m_lat[m] == 0) begin
          m_lat[m] = 1;
          m_lim[m] = lim_of(hburst);
        end
        m_beats[m] = (m_beats[m] == 31) ? 31 : m_beats[m] + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] ag, eg;
    logic [1:0] am;
    logic       as, al;
    for (int m = 0; m < 2; m++) begin
      ag = (m == 0) ? gnt_f : gnt_r;
      am = (m == 0) ? mst_f : mst_r;
      as = (m == 0) ? sel_f : sel_r;
      al = (m == 0) ? last_f : last_r;
      eg = (m_owner[m] < 0) ? 4'd0 : (4'd1 << m_owner[m]);
      chk($sformatf("%s.m%0d.gnt", tag, m), ag, eg);
      chk($sformatf("%s.m%0d.master", tag, m), am, (m_owner[m] < 0) ? 0 : m_owner[m]);
      chk($sformatf("%s.m%0d.sel", tag, m), as, (m_owner[m] < 0) ? 0 : 1);
      chk($sformatf("%s.m%0d.last", tag, m), al, exp_last(m));
      chk($sformatf("%s.m%0d.onehot", tag, m), $onehot0(ag), 1);
    end
  endtask

  // Check outputs against the model, advance one clock, confirm grants held through stalls.
  task automatic step(input string tag);
    logic [3:0] pf, pr;
    logic       w;
    check_model(tag);
    pf = gnt_f;
    pr = gnt_r;
    w  = hwait;
    model_step(0);
    model_step(1);
    @(posedge hclk);
    @(negedge hclk);
    if (w) begin
      chk({tag, ".stall.fix"}, gnt_f, pf);
      chk({tag, ".stall.rr"}, gnt_r, pr);
    end
  endtask

  task automatic do_reset();
    hreset_n = 1'b0;
    hreq     = 4'd0;
    htrans   = IDLE;
    hburst   = INCR;
    hwait    = 1'b0;
    model_reset();
    repeat (2) @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  initial begin
    hreset_n = 1'b0;
    hreq     = 4'd0;
    htrans   = IDLE;
    hburst   = INCR;
    hwait    = 1'b0;
    model_reset();

    // Fixed 1010 pick, then INCR4 with a three-cycle stall on beat 2.
    add(1, 4'b1010, INCR,   IDLE,   0, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b1010, SINGLE, NONSEQ, 0, 4'b0010, 1, 4'b0010, 1);
    add(0, 4'b0000, INCR,   IDLE,   0, 4'b0010, 0, 4'b1000, 0);
    add(0, 4'b0001, INCR4,  IDLE,   0, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0001, INCR4,  NONSEQ, 0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, INCR4,  SEQ,    1, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, INCR4,  SEQ,    1, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, INCR4,  SEQ,    1, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, INCR4,  SEQ,    0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, INCR4,  SEQ,    0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0000, INCR4,  SEQ,    0, 4'b0001, 1, 4'b0001, 1);
    add(0, 4'b0000, INCR,   IDLE,   0, 4'b0000, 0, 4'b0000, 0);
    // All masters requesting SINGLE bursts: round-robin rotates with no gaps.
    add(1, 4'b1111, INCR,   IDLE,   0, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b1111, SINGLE, NONSEQ, 0, 4'b0001, 1, 4'b0001, 1);
    add(0, 4'b1111, SINGLE, NONSEQ, 0, 4'b0001, 1, 4'b0010, 1);
    add(0, 4'b1111, SINGLE, NONSEQ, 0, 4'b0001, 1, 4'b0100, 1);
    add(0, 4'b1111, SINGLE, NONSEQ, 0, 4'b0001, 1, 4'b1000, 1);
    add(0, 4'b1111, SINGLE, NONSEQ, 0, 4'b0001, 1, 4'b0001, 1);
    add(0, 4'b0000, INCR,   IDLE,   0, 4'b0001, 0, 4'b0010, 0);
    add(0, 4'b0000, INCR,   IDLE,   0, 4'b0000, 0, 4'b0000, 0);
    // Master 2 INCR for five beats, then IDLE hands the bus to master 0.
    add(1, 4'b0100, INCR,   IDLE,   0, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0100, INCR,   NONSEQ, 0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, INCR,   SEQ,    0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, INCR,   SEQ,    0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, INCR,   SEQ,    0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, INCR,   SEQ,    0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0001, INCR,   IDLE,   0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0001, INCR,   IDLE,   0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0000, INCR,   IDLE,   0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0000, INCR,   IDLE,   0, 4'b0000, 0, 4'b0000, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      hreq   = tbl[i].req;
      hburst = tbl[i].burst;
      htrans = tbl[i].trans;
      hwait  = tbl[i].wt;
      #1;
      chk($sformatf("vec%0d.fix.gnt", i), gnt_f, tbl[i].gf);
      chk($sformatf("vec%0d.fix.last", i), last_f, tbl[i].lf);
      chk($sformatf("vec%0d.rr.gnt", i), gnt_r, tbl[i].gr);
      chk($sformatf("vec%0d.rr.last", i), last_r, tbl[i].lr);
      step($sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of beat 6 of an INCR8, then a clean restart.
    do_reset();
    hreq   = 4'b0100;
    hburst = INCR8;
    htrans = IDLE;
    #1;
    step("r8.grant");
    for (int b = 0; b < 5; b++) begin
      htrans = (b == 0) ? NONSEQ : SEQ;
      #1;
      chk($sformatf("r8.beat%0d.last", b), last_f, 0);
      step($sformatf("r8.beat%0d", b));
    end
    htrans = SEQ;
    #1;
    chk("r8.beat6.gnt", gnt_f, 4'b0100);
    #2;
    hreset_n = 1'b0;
    model_reset();
    #1;
    chk("arst.fix.gnt", gnt_f, 0);
    chk("arst.fix.sel", sel_f, 0);
    chk("arst.fix.master", mst_f, 0);
    chk("arst.fix.last", last_f, 0);
    chk("arst.rr.gnt", gnt_r, 0);
    chk("arst.rr.last", last_r, 0);
    @(negedge hclk);
    hreset_n = 1'b1;
    hreq     = 4'b0100;
    htrans   = IDLE;
    #1;
    step("post.grant");
    chk("post.fix.gnt", gnt_f, 4'b0100);
    chk("post.rr.gnt", gnt_r, 4'b0100);
    for (int b = 0; b < 8; b++) begin
      htrans = (b == 0) ? NONSEQ : SEQ;
      #1;
      chk($sformatf("post.beat%0d.last", b), last_f, (b == 7) ? 1 : 0);
      step($sformatf("post.beat%0d", b));
    end
    hreq   = 4'd0;
    htrans = IDLE;
    hburst = INCR;
    #1;
    step("post.drain0");
    step("post.drain1");

    // Random traffic against the model, in both arbitration modes at once.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int r;
      if ($urandom_range(0, 7) == 0) hreq = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r == 0) htrans = IDLE;
      else if (r == 1) htrans = BUSY;
      else if (r < 4) htrans = NONSEQ;
      else htrans = SEQ;
      if ($urandom_range(0, 5) == 0) hburst = burst_type'($urandom_range(0, 7));
      hwait = ($urandom_range(0, 3) == 0);
      #1;
      step($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_burst_arbiter.md
AHB_BURST_ARBITER -- requirements
Module: ahb_burst_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 4, legal range 2..16: number of requesting masters.
REQ-002 Parameter ARB_MODE, default 0: 0 selects fixed priority, 1 selects round robin.
REQ-003 Parameter MIDX_W, default $clog2(MASTER_NUM): width of the master index.
REQ-004 hclk  in  1  sole clock; all state is updated on the rising edge.
REQ-005 hreset_n  in  1  asynchronous, active-low reset.
REQ-006 hreq  in  MASTER_NUM  per-master bus request; bit i belongs to master i.
REQ-007 hburst  in  burst_type  burst type of the currently granted master (muxed upstream).
REQ-008 htrans  in  trans_type  transfer type of the currently granted master.
REQ-009 hwait  in  1  slave stall; 1 means the current beat is not accepted.
REQ-010 hgrant  out  MASTER_NUM  one-hot registered grant.
REQ-011 hsel  out  1  slave select, equal to |hgrant.
REQ-012 hmaster  out  MIDX_W  binary index of the granted master; 0 when hsel=0.
REQ-013 hlast  out  1  high during the final beat of the granted burst.

Function
REQ-014 A beat is accepted when hsel=1, hwait=0 and htrans is NONSEQ or SEQ.
REQ-015 FSM states:
- IDLE: no grant.
- BURST: grant held.
REQ-016 IDLE -> BURST when |hreq=1; the winner appears on hgrant one cycle after the request is sampled.
REQ-017 Beat limit by hburst, latched at the first accepted NONSEQ beat:
- SINGLE = 1
- WRAP4/INCR4 = 4
- WRAP8/INCR8 = 8
- WRAP16/INCR16 = 16
- INCR = unbounded
REQ-018 The 5-bit beat counter clears on entry to BURST and increments on every accepted beat.
REQ-019 hlast = 1 when the count equals limit-1 and hsel=1; hlast is always 0 for INCR.
REQ-020 BURST ends on any of:
- acceptance of the beat with hlast=1;
- for INCR, htrans sampled IDLE or NONSEQ while hwait=0, after at least one accepted beat;
- the granted master deasserting hreq while htrans=IDLE and hwait=0 (early termination).
REQ-021 At the end edge the arbiter re-arbitrates:
- if any hreq is pending, the new winner is granted on that same edge (zero dead cycles) and the FSM stays in BURST;
- otherwise the FSM goes to IDLE with hgrant=0.
REQ-022 BUSY beats and hwait=1 cycles never advance the counter and never release the grant.
REQ-023 In fixed mode the lowest-index requester wins.
REQ-024 In round-robin mode the search starts at (last granted index + 1) mod MASTER_NUM; the pointer updates only when a burst ends and starts at 0 after reset.
REQ-025 Requests arriving mid-burst are ignored until the burst ends; no preemption occurs.
REQ-026 hgrant is never multi-hot and never changes while hwait=1.

Reset
REQ-027 Assertion of hreset_n=0 at any time, including mid-burst, immediately (asynchronously) forces:
- hgrant=0, hsel=0, hmaster=0, hlast=0;
- FSM=IDLE, counter=0, round-robin pointer=0.
REQ-028 After deassertion, the first grant follows REQ-016.

Structure
REQ-029 burst_type and trans_type (IDLE, BUSY, NONSEQ, SEQ) and the beat-limit lookup function live in AHB_package; the block defines no local copies.
REQ-030 The combinational winner selection (request vector plus start pointer in, one-hot winner out) lives in one sub-module, ahb_rr_pick; fixed mode instantiates it with the pointer tied to 0.
REQ-031 The RTL contains no latches, and every case statement has a default arm.

Verification (MASTER_NUM=4)
REQ-032 Fixed mode, hreq=4'b1010 from reset -> hgrant=4'b0010 one cycle later, hmaster=1.
REQ-033 Master 0 issues an INCR4 with hwait=1 on beat 2 for 3 cycles -> 4 beats counted; hlast is high only on beat 4; grant held throughout the stall.
REQ-034 Round-robin mode, hreq=4'b1111 held, each master issuing SINGLE -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-035 Master 2 issues an INCR, then drives htrans=IDLE after 5 beats with hreq=4'b0001 -> grant moves to master 0 on that edge; hlast never asserted.
REQ-036 hreset_n pulled low during beat 6 of an INCR8 -> all outputs 0 asynchronously; after release with hreq=4'b0100 -> hgrant=4'b0100, counter restarts from 0.
REQ-037 Random traffic with concurrent assertions -> hgrant stays one-hot or zero, stays stable while hwait=1, and the beat count equals the burst length for every fixed-length burst.
